// File: rtl/uart8_tx_arbiter.sv
// uart8_tx_arbiter: round-robin sharing of one Uart8 transmit side among NUM_REQ byte streams.
// Define UART_ARB_PACKET_LOCK_EN to hold the grant until a reqLast byte has been sent.
module uart8_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ID_WIDTH      = 2,
  parameter int START_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   reqValid,
  input  logic [8*NUM_REQ-1:0] reqData,
  input  logic [NUM_REQ-1:0]   reqLast,
  output logic [NUM_REQ-1:0]   reqReady,
  output logic [ID_WIDTH-1:0]  grantId,
  output logic                 uartTxEn,
  output logic                 uartTxStart,
  output logic [7:0]           uartTxData,
  input  logic                 uartTxBusy,
  output logic                 byteSent,
  output logic                 timeoutErr,
  output logic                 active
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    SEND
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_WIDTH-1:0] r_grantId;
  logic [ID_WIDTH-1:0] w_pick;
  logic                w_found;
  logic [7:0]          r_txData;
  logic                r_lastQ;
  logic                r_txEn;
  logic [15:0]         r_cnt;
  logic                w_pktOpen;
  logic                w_accept;
  logic                w_done;
  logic                w_timeout;

  function automatic logic [ID_WIDTH-1:0] wrap(input int v);
    return ID_WIDTH'(v % NUM_REQ);
  endfunction

  // Walk downward so the nearest valid index after grantId wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_grantId;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (reqValid[wrap(int'(r_grantId) + k)]) begin
        w_found = 1'b1;
        w_pick  = wrap(int'(r_grantId) + k);
      end
    end
  end

  assign w_accept = (r_state == LOAD) && reqValid[r_grantId];

  always_comb begin
    w_next    = r_state;
    reqReady  = '0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) w_next = LOAD;
      end
      LOAD: begin
        reqReady[r_grantId] = 1'b1;
        if (reqValid[r_grantId]) w_next = START;
        else if (!w_pktOpen) w_next = IDLE;
      end
      START: begin
        if (uartTxBusy) begin
          w_next = SEND;
        end else if (r_cnt == 16'(START_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      SEND: begin
        if (!uartTxBusy) begin
          w_done = 1'b1;
          w_next = (w_pktOpen && !r_lastQ) ? LOAD : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grantId <= ID_WIDTH'(NUM_REQ - 1);
      r_txData  <= 8'h00;
      r_lastQ   <= 1'b0;
      r_cnt     <= '0;
      r_txEn    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_txEn  <= 1'b1;
      if (r_state == IDLE && w_found) r_grantId <= w_pick;
      if (w_accept) begin
        r_txData <= reqData[{r_grantId, 3'b000} +: 8];
        r_lastQ  <= reqLast[r_grantId];
        r_cnt    <= '0;
      end else if (r_state == START) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

`ifdef UART_ARB_PACKET_LOCK_EN
  logic r_pktOpen;

  always_ff @(posedge clk) begin
    if (reset) r_pktOpen <= 1'b0;
    else if (r_state == IDLE && w_found) r_pktOpen <= 1'b1;
    else if (w_timeout || (w_done && r_lastQ)) r_pktOpen <= 1'b0;
  end

  assign w_pktOpen = r_pktOpen;
`else
  assign w_pktOpen = 1'b0;
`endif

  assign grantId     = r_grantId;
  assign uartTxEn    = r_txEn;
  assign uartTxStart = (r_state == START);
  assign uartTxData  = r_txData;
  assign byteSent    = w_done;
  assign timeoutErr  = w_timeout;
  assign active      = (r_state != IDLE);

endmodule

// File: tb/tb_uart8_tx_arbiter.sv
// Scoreboard bench for uart8_tx_arbiter with a behavioural Uart8 busy model.
// Lock-specific scenarios follow UART_ARB_PACKET_LOCK_EN.
module tb_uart8_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   reqValid = '0;
  logic [8*N-1:0] reqData = '0;
  logic [N-1:0]   reqLast = '1;
  logic [N-1:0]   reqReady;
  logic [1:0]     grantId;
  logic           uartTxEn;
  logic           uartTxStart;
  logic [7:0]     uartTxData;
  logic           uartTxBusy = 1'b0;
  logic           byteSent;
  logic           timeoutErr;
  logic           active;

  int n_chk = 0;
  int n_fail = 0;
  int n_ev = 0;
  bit uart_en = 1'b1;

  typedef struct {
    bit         tmo;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  uart8_tx_arbiter #(
    .NUM_REQ(N),
    .ID_WIDTH(2),
    .START_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reqValid(reqValid),
    .reqData(reqData),
    .reqLast(reqLast),
    .reqReady(reqReady),
    .grantId(grantId),
    .uartTxEn(uartTxEn),
    .uartTxStart(uartTxStart),
    .uartTxData(uartTxData),
    .uartTxBusy(uartTxBusy),
    .byteSent(byteSent),
    .timeoutErr(timeoutErr),
    .active(active)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Uart8 stand-in: busy rises 3 cycles after start, frame lasts 20 cycles.
  always begin
    @(negedge clk);
    if (uart_en && uartTxStart) begin
      repeat (3) @(posedge clk);
      #1 uartTxBusy = 1'b1;
      repeat (20) @(posedge clk);
      #1 uartTxBusy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && (byteSent || timeoutErr)) begin
      chk("sent_tmo_excl", 32'(byteSent & timeoutErr), 0);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: sent=%0b tmo=%0b id=%0d data=%0h",
                 byteSent, timeoutErr, grantId, uartTxData);
      end else begin
        e = q.pop_front();
        chk("event_kind", 32'(timeoutErr), 32'(e.tmo));
        chk("event_grant", 32'(grantId), 32'(e.id));
        chk("event_data", 32'(uartTxData), 32'(e.data));
      end
      n_ev++;
    end
  end

  task automatic check_rst(input string tag);
    chk({tag, "_ready"}, 32'(reqReady), 0);
    chk({tag, "_start"}, 32'(uartTxStart), 0);
    chk({tag, "_txen"}, 32'(uartTxEn), 0);
    chk({tag, "_sent"}, 32'(byteSent), 0);
    chk({tag, "_tmo"}, 32'(timeoutErr), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_grant"}, 32'(grantId), 3);
    chk({tag, "_data"}, 32'(uartTxData), 0);
  endtask

  task automatic do_reset();
    reqValid = '0;
    reqLast  = '1;
    reset    = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic wait_ev(input int target, input int budget);
    int c;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (n_ev < target && c < budget);
    chk("event_wait", 32'(n_ev >= target), 1);
  endtask

  initial begin
    int base;
    int starts;
    int c;

    // single byte from requester 2
    @(posedge clk);
    #1;
    check_rst("rst0");
    reset = 1'b0;
    reqValid = 4'b0100;
    reqData[23:16] = 8'hA5;
    @(posedge clk);
    #1;
    chk("t1_ready", 32'(reqReady), 32'h4);
    chk("t1_grant", 32'(grantId), 2);
    chk("t1_txen", 32'(uartTxEn), 1);
    chk("t1_start_early", 32'(uartTxStart), 0);
    @(posedge clk);
    #1;
    chk("t1_start", 32'(uartTxStart), 1);
    chk("t1_data", 32'(uartTxData), 32'hA5);
    chk("t1_ready_off", 32'(reqReady), 0);
    reqValid = '0;
    base = n_ev;
    q.push_back('{1'b0, 2'd2, 8'hA5});
    wait_ev(base + 1, 100);
    chk("t1_grant_end", 32'(grantId), 2);
    chk("t1_idle", 32'(active), 0);

    // all four requesters continuously valid
    do_reset();
    reqData = {8'h13, 8'h12, 8'h11, 8'h10};
    base = n_ev;
    q.push_back('{1'b0, 2'd0, 8'h10});
    q.push_back('{1'b0, 2'd1, 8'h11});
    q.push_back('{1'b0, 2'd2, 8'h12});
    q.push_back('{1'b0, 2'd3, 8'h13});
    q.push_back('{1'b0, 2'd0, 8'h10});
    reqValid = '1;
    wait_ev(base + 5, 400);
    reqValid = '0;
    repeat (2) @(posedge clk);
    #1;

`ifdef UART_ARB_PACKET_LOCK_EN
    // requester 1 holds the grant for a 3-byte packet
    do_reset();
    reqData = {8'h00, 8'h00, 8'h31, 8'h40};
    reqLast = 4'b0001;
    reqValid = 4'b0010;
    @(posedge clk);
    #1;
    chk("lk_grant", 32'(grantId), 1);
    reqValid = 4'b0011;
    base = n_ev;
    q.push_back('{1'b0, 2'd1, 8'h31});
    q.push_back('{1'b0, 2'd1, 8'h32});
    q.push_back('{1'b0, 2'd1, 8'h33});
    q.push_back('{1'b0, 2'd0, 8'h40});
    for (int b = 0; b < 3; b++) begin
      c = 0;
      while (!reqReady[1] && c < 100) begin
        @(posedge clk);
        #1;
        c++;
      end
      chk("lk_ready_wait", 32'(reqReady[1]), 1);
      @(posedge clk);
      #1;
      reqData[15:8] = 8'h32 + 8'(b);
      reqLast[1] = (b == 1);
      if (b == 2) reqValid[1] = 1'b0;
    end
    wait_ev(base + 4, 300);
    reqValid = '0;
    repeat (2) @(posedge clk);
    #1;
`else
    // requester withdraws in LOAD
    do_reset();
    reqValid = 4'b1000;
    reqData[31:24] = 8'h77;
    @(posedge clk);
    #1;
    chk("drop_ready", 32'(reqReady), 32'h8);
    reqValid = '0;
    @(posedge clk);
    #1;
    chk("drop_idle", 32'(active), 0);
    starts = 0;
    repeat (6) begin
      @(negedge clk);
      if (uartTxStart) starts++;
    end
    chk("drop_no_start", 32'(starts), 0);
    @(posedge clk);
    #1;
`endif

    // start timeout with the UART silent
    do_reset();
    uart_en = 1'b0;
    reqData[7:0] = 8'h5A;
    reqValid = 4'b0001;
    q.push_back('{1'b1, 2'd0, 8'h5A});
    starts = 0;
    c = 0;
    while (c < 60) begin
      @(negedge clk);
      c++;
      if (uartTxStart) starts++;
      if (timeoutErr) break;
    end
    chk("tmo_start_cycles", 32'(starts), 8);
    @(posedge clk);
    #1;
    chk("tmo_idle", 32'(active), 0);
    chk("tmo_start_off", 32'(uartTxStart), 0);
    uart_en = 1'b1;
    reqData[15:8] = 8'h6B;
    reqValid = 4'b0011;
    base = n_ev;
    q.push_back('{1'b0, 2'd1, 8'h6B});
    wait_ev(base + 1, 100);
    reqValid = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset while the frame is in SEND
    do_reset();
    reqData[15:8] = 8'h21;
    reqValid = 4'b0010;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(uartTxBusy && !uartTxStart && active) && c < 100);
    chk("rs_in_send", 32'(uartTxBusy && !uartTxStart && active), 1);
    @(posedge clk);
    #1;
    reqValid = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_rst("rst_send");
    reset = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (uartTxBusy && c < 60);
    chk("rs_busy_drain", 32'(uartTxBusy), 0);
    @(posedge clk);
    #1;
    reqData[7:0] = 8'h0C;
    reqData[23:16] = 8'h2C;
    reqValid = 4'b0101;
    base = n_ev;
    q.push_back('{1'b0, 2'd0, 8'h0C});
    @(posedge clk);
    #1;
    chk("rs_grant0", 32'(grantId), 0);
    wait_ev(base + 1, 100);
    reqValid = '0;
    repeat (3) @(posedge clk);
    #1;

    chk("queue_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
